// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory port, redirect controls and the IF/ID outputs.
// The fetch stage takes the master modport; the surrounding pipeline/memory takes slave.
interface if_stage_if;
    logic [1:0]  PCSrc;
    logic        IDflush;
    logic        stall;
    logic [31:0] jr_addr;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_ready;
    logic [31:0] ID_ins;
    logic [31:0] ID_pc;
    logic        ID_valid;
    logic [31:0] redirect_cnt;

    modport master (
        input  PCSrc, IDflush, stall, jr_addr, im_rdata, im_ready,
        output im_addr, ID_ins, ID_pc, ID_valid, redirect_cnt
    );

    modport slave (
        output PCSrc, IDflush, stall, jr_addr, im_rdata, im_ready,
        input  im_addr, ID_ins, ID_pc, ID_valid, redirect_cnt
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Define IF_REDIRECT_CNT_EN to build the accepted-redirect counter; otherwise redirect_cnt is 0.
module if_stage (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JR     = 2'd2,
        SRC_JUMP   = 2'd3
    } pc_src_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        valid_q, valid_d;

    logic [31:0] seq_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] redirect_target;
    logic        redirect_ok;
    pc_src_e     pc_src;
    logic        unused_jr_low;

    assign pc_src        = pc_src_e'(bus.PCSrc);
    assign seq_pc        = pc_q + 32'd4;
    assign id_pc_plus4   = id_pc_q + 32'd4;
    assign branch_target = id_pc_plus4 + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
    assign jump_target   = {id_pc_plus4[31:28], ins_q[25:0], 2'b00};
    assign jr_target     = {bus.jr_addr[31:2], 2'b00};
    assign unused_jr_low = ^bus.jr_addr[1:0];

    // Only a real instruction in ID may redirect; a stall freezes the decision.
    assign redirect_ok = (pc_src != SRC_SEQ) && valid_q && !bus.stall;

    always_comb begin
        redirect_target = seq_pc;
        case (pc_src)
            SRC_BRANCH: redirect_target = branch_target;
            SRC_JR:     redirect_target = jr_target;
            SRC_JUMP:   redirect_target = jump_target;
            default:    redirect_target = seq_pc;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
        pc_d    = pc_q;
        ins_d   = ins_q;
        id_pc_d = id_pc_q;
        valid_d = valid_q;
        if (!bus.stall) begin
            if (redirect_ok) begin
                pc_d    = redirect_target;
                ins_d   = '0;
                valid_d = 1'b0;
            end else if (bus.IDflush) begin
                ins_d   = '0;
                valid_d = 1'b0;
                if (bus.im_ready) pc_d = seq_pc;
            end else if (bus.im_ready) begin
                pc_d    = seq_pc;
                ins_d   = bus.im_rdata;
                id_pc_d = pc_q;
                valid_d = 1'b1;
            end else begin
                ins_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            id_pc_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            id_pc_q <= id_pc_d;
            valid_q <= valid_d;
        end
    end

`ifdef IF_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_q <= '0;
        end else if (redirect_ok) begin
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign bus.redirect_cnt = redirect_cnt_q;
`else
    assign bus.redirect_cnt = '0;
`endif

    assign bus.im_addr  = pc_q;
    assign bus.ID_ins   = ins_q;
    assign bus.ID_pc    = id_pc_q;
    assign bus.ID_valid = valid_q;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vectors followed by a randomized run,
// each edge compared against a behavioural model of the fetch rules.
module tb_if_stage;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef IF_REDIRECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    if_stage_if bus ();

    if_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc, m_ins, m_pid, m_cnt;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_ins   = 32'h0;
        m_pid   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_edge(input logic ready, input logic [31:0] rdata, input logic [1:0] src,
                              input logic flush, input logic stl, input logic [31:0] jr);
        logic [31:0] off;
        logic [31:0] tgt;
        if (stl) begin
            // everything holds
        end else if (src != 2'd0 && m_valid) begin
            off = {{16{m_ins[15]}}, m_ins[15:0]};
            case (src)
                2'd1:    tgt = m_pid + 32'd4 + off * 32'd4;
                2'd2:    tgt = jr & ~32'd3;
                default: tgt = ((m_pid + 32'd4) & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) << 2);
            endcase
            m_pc    = tgt;
            m_ins   = 32'h0;
            m_valid = 1'b0;
            if (CNT_EN) m_cnt = m_cnt + 32'd1;
        end else if (flush) begin
            m_ins   = 32'h0;
            m_valid = 1'b0;
            if (ready) m_pc = m_pc + 32'd4;
        end else if (ready) begin
            m_ins   = rdata;
            m_pid   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else begin
            m_ins   = 32'h0;
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ":im_addr"},      bus.im_addr,          m_pc);
        check({tag, ":ID_ins"},       bus.ID_ins,           m_ins);
        check({tag, ":ID_pc"},        bus.ID_pc,            m_pid);
        check({tag, ":ID_valid"},     {31'b0, bus.ID_valid}, {31'b0, m_valid});
        check({tag, ":redirect_cnt"}, bus.redirect_cnt,     m_cnt);
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare 1 time unit later.
    task automatic step(input logic ready, input logic [31:0] rdata, input logic [1:0] src,
                        input logic flush, input logic stl, input logic [31:0] jr, input string tag);
        @(negedge clk);
        bus.im_ready = ready;
        bus.im_rdata = rdata;
        bus.PCSrc    = src;
        bus.IDflush  = flush;
        bus.stall    = stl;
        bus.jr_addr  = jr;
        #1 check({tag, ":pre_im_addr"}, bus.im_addr, m_pc);
        @(posedge clk);
        model_edge(ready, rdata, src, flush, stl, jr);
        #1 check_all(tag);
    endtask

    task automatic fetch(input logic [31:0] rdata, input string tag);
        step(1'b1, rdata, 2'd0, 1'b0, 1'b0, 32'h0, tag);
    endtask

    initial begin
        logic [31:0] cnt_before;
        rst          = 1'b1;
        bus.PCSrc    = 2'd0;
        bus.IDflush  = 1'b0;
        bus.stall    = 1'b0;
        bus.jr_addr  = 32'h0;
        bus.im_rdata = 32'h0;
        bus.im_ready = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        check("reset:im_addr_const", bus.im_addr, 32'h0000_3000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First fetch after reset
        fetch(32'h2008_0001, "fetch0");
        check("fetch0:ID_ins_const", bus.ID_ins, 32'h2008_0001);
        check("fetch0:ID_pc_const",  bus.ID_pc,  32'h0000_3000);
        check("fetch0:im_addr_const", bus.im_addr, 32'h0000_3004);

        // Branch with offset -1 from 0x3008 loops back to itself
        fetch(32'h0000_0020, "fetch1");
        fetch(32'h1000_FFFF, "fetch_beq");
        cnt_before = bus.redirect_cnt;
        step(1'b1, 32'hDEAD_BEEF, 2'd1, 1'b0, 1'b0, 32'h0, "beq");
        check("beq:im_addr_const", bus.im_addr, 32'h0000_3008);
        check("beq:ID_valid_const", {31'b0, bus.ID_valid}, 32'h0);
        check("beq:cnt_const", bus.redirect_cnt, CNT_EN ? cnt_before + 32'd1 : 32'h0);

        // jal then jr with misaligned register value
        fetch(32'h0000_0001, "fetch3008");
        fetch(32'h0000_0002, "fetch300c");
        fetch(32'h0C00_0C10, "fetch_jal");
        check("jal:ID_pc_const", bus.ID_pc, 32'h0000_3010);
        step(1'b1, 32'h1234_5678, 2'd3, 1'b0, 1'b0, 32'h0, "jal");
        check("jal:im_addr_const", bus.im_addr, 32'h0000_3040);
        fetch(32'h0000_0008, "fetch_jr");
        step(1'b1, 32'h8765_4321, 2'd2, 1'b0, 1'b0, 32'h0000_3103, "jr");
        check("jr:im_addr_const", bus.im_addr, 32'h0000_3100);

        // Stall with a pending branch: everything holds, then redirect is taken
        fetch(32'h1111_1111, "fetch_stall");
        cnt_before = bus.redirect_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 2'd1, 1'b0, 1'b1, 32'h0, "stall");
            check("stall:im_addr_const", bus.im_addr, 32'h0000_3104);
            check("stall:ID_ins_const",  bus.ID_ins,  32'h1111_1111);
            check("stall:cnt_const",     bus.redirect_cnt, cnt_before);
        end
        step(1'b1, 32'h0, 2'd1, 1'b0, 1'b0, 32'h0, "stall_release");
        check("stall_release:im_addr_const", bus.im_addr, 32'h0000_7548);

        // im_ready low: two bubbles with PC held
        step(1'b0, 32'hFFFF_0000, 2'd0, 1'b0, 1'b0, 32'h0, "not_ready0");
        step(1'b0, 32'hFFFF_0001, 2'd0, 1'b0, 1'b0, 32'h0, "not_ready1");
        check("not_ready:im_addr_const", bus.im_addr, 32'h0000_7548);

        // PC wrap at the top of the address space
        fetch(32'h0000_0003, "fetch_pre_wrap");
        step(1'b1, 32'h0, 2'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, "to_top");
        check("to_top:im_addr_const", bus.im_addr, 32'hFFFF_FFFC);
        fetch(32'h2222_2222, "wrap");
        check("wrap:im_addr_const", bus.im_addr, 32'h0000_0000);
        check("wrap:ID_pc_const",   bus.ID_pc,   32'hFFFF_FFFC);

        // Flush with and without a ready word
        step(1'b1, 32'h3333_3333, 2'd0, 1'b1, 1'b0, 32'h0, "flush_ready");
        step(1'b0, 32'h4444_4444, 2'd0, 1'b1, 1'b0, 32'h0, "flush_idle");
        // PCSrc is ignored while ID holds a bubble
        step(1'b1, 32'h5555_5555, 2'd3, 1'b0, 1'b0, 32'h0, "src_on_bubble");
        // Redirect takes priority over flush
        step(1'b1, 32'h6666_6666, 2'd2, 1'b1, 1'b0, 32'h0000_4000, "redirect_vs_flush");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom, "rand");
        end

        // Asynchronous reset in the middle of a stalled cycle with a pending redirect
        fetch(32'h7777_7777, "fetch_pre_rst");
        @(negedge clk);
        bus.stall = 1'b1;
        bus.PCSrc = 2'd1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst:im_addr_const", bus.im_addr, 32'h0000_3000);
        @(posedge clk);
        #1 check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h8888_8888, "post_rst");
        check("post_rst:ID_pc_const", bus.ID_pc, 32'h0000_3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
